// File: rtl/dsp_brr_encoder.sv
// ---------------------------------------------------------------------------
// dsp_brr_encoder
//
// Compresses a stream of 16-bit signed PCM samples into 9-byte BRR blocks
// (one header byte followed by eight bytes of packed 4-bit residuals) and
// writes them to audio RAM through a request/grant byte port. Each block
// holds 16 samples.
//
// The shift (range) of each block is chosen open-loop from the raw input
// samples. Quantisation is closed-loop: every nibble is predicted from the
// same reconstructed history the voice decoder will have, so decoded audio
// matches the encoder's internal reconstruction bit for bit.
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   start, start_address  begin a stream at the given RAM address (IDLE only)
//   filter_select         predictor filter for the block (captured on sample 0)
//   last_block, loop_flag header flag bits (captured on sample 0)
//   sample_in/valid/ready PCM input handshake, ready only while filling
//   ram_address/write_data/write_request/write_grant
//                         byte write port; address and data stay stable
//                         while a request waits for its grant
//   busy                  high whenever the encoder is not idle
//   block_done            one-cycle pulse after a block's last byte is taken
//   state                 current FSM state
// ---------------------------------------------------------------------------
module dsp_brr_encoder #(
    parameter int MAX_RANGE = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] start_address,
    input  logic [1:0]  filter_select,
    input  logic        last_block,
    input  logic        loop_flag,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_write_data,
    output logic        ram_write_request,
    input  logic        ram_write_grant,
    output logic        busy,
    output logic        block_done,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_FILL         = 3'd1,
        S_ANALYZE      = 3'd2,
        S_ENCODE       = 3'd3,
        S_WRITE_HEADER = 3'd4,
        S_WRITE_DATA   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        addr_q, addr_d;
    logic signed [15:0] s1_q, s1_d, s2_q, s2_d;
    logic signed [15:0] buf_q [16];
    logic signed [15:0] buf_d [16];
    logic [7:0]         data_q [8];
    logic [7:0]         data_d [8];
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         range_q, range_d;
    logic [1:0]         filter_q, filter_d;
    logic               last_q, last_d;
    logic               loop_q, loop_d;
    logic [2:0]         byte_q, byte_d;
    logic               req_q, req_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               done_q, done_d;

    // Signed division by 2^k truncating toward zero, matching the decoder's '/'.
    function automatic logic signed [31:0] div_pow2(input logic signed [31:0] x, input int k);
        logic signed [31:0] bias;
        bias = x[31] ? ((32'sd1 <<< k) - 32'sd1) : 32'sd0;
        return (x + bias) >>> k;
    endfunction

    function automatic logic signed [31:0] predict(input logic [1:0] f,
                                                   input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic signed [31:0] ax;
        logic signed [31:0] bx;
        ax = a;
        bx = b;
        case (f)
            2'd1:    return div_pow2(ax * 32'sd15, 4);
            2'd2:    return div_pow2(ax * 32'sd61, 5) + div_pow2(bx * (-32'sd15), 4);
            2'd3:    return div_pow2(ax * 32'sd115, 6) + div_pow2(bx * (-32'sd13), 4);
            default: return 32'sd0;
        endcase
    endfunction

    // Datapath for both passes over the buffer.
    logic signed [15:0] a_prev1, a_prev2;
    logic signed [31:0] a_cur, a_resid, a_shift;
    logic [3:0]         a_range;
    logic signed [31:0] e_pred, e_diff, e_shift;
    logic [3:0]         e_nib;
    logic signed [15:0] e_dec;

    always_comb begin
        // Open-loop analysis predicts from raw neighbours; the first two
        // samples of a block reach back into the reconstructed history.
        a_prev1 = (idx_q == 4'd0) ? s1_q : buf_q[idx_q - 4'd1];
        if (idx_q == 4'd0)
            a_prev2 = s2_q;
        else if (idx_q == 4'd1)
            a_prev2 = s1_q;
        else
            a_prev2 = buf_q[idx_q - 4'd2];
        a_cur   = buf_q[idx_q];
        a_resid = a_cur - predict(filter_q, a_prev1, a_prev2);
        a_shift = '0;
        a_range = 4'(MAX_RANGE);
        // Walking down leaves the smallest shift that still fits a nibble.
        for (int r = MAX_RANGE; r >= 0; r--) begin
            a_shift = a_resid >>> r;
            if (a_shift >= -32'sd8 && a_shift <= 32'sd7)
                a_range = 4'(r);
        end

        // Closed-loop quantisation against the decoder's own history.
        e_pred  = predict(filter_q, s1_q, s2_q);
        e_diff  = a_cur - e_pred;
        e_shift = e_diff >>> range_q;
        if (e_shift > 32'sd7)
            e_nib = 4'h7;
        else if (e_shift < -32'sd8)
            e_nib = 4'h8;
        else
            e_nib = e_shift[3:0];
        // Reconstruction wraps to 16 bits exactly like the decoder.
        e_dec = 16'(($signed({{28{e_nib[3]}}, e_nib}) <<< range_q) + e_pred);
    end

    // Next-state logic for the block pipeline and the RAM write sequencer.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        buf_d    = buf_q;
        data_d   = data_q;
        idx_d    = idx_q;
        range_d  = range_q;
        filter_d = filter_q;
        last_d   = last_q;
        loop_d   = loop_q;
        byte_d   = byte_q;
        req_d    = req_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    addr_d  = start_address;
                    s1_d    = '0;
                    s2_d    = '0;
                    idx_d   = '0;
                end
            end
            S_FILL: begin
                if (sample_valid) begin
                    buf_d[idx_q] = sample_in;
                    if (idx_q == 4'd0) begin
                        filter_d = filter_select;
                        last_d   = last_block;
                        loop_d   = loop_flag;
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = S_ANALYZE;
                        range_d = '0;
                    end
                end
            end
            S_ANALYZE: begin
                if (a_range > range_q)
                    range_d = a_range;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15)
                    state_d = S_ENCODE;
            end
            S_ENCODE: begin
                s2_d = s1_q;
                s1_d = e_dec;
                if (idx_q[0] == 1'b0)
                    data_d[idx_q[3:1]][7:4] = e_nib;
                else
                    data_d[idx_q[3:1]][3:0] = e_nib;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = S_WRITE_HEADER;
                    req_d   = 1'b1;
                    wdata_d = {range_q, filter_q, loop_q, last_q};
                end
            end
            S_WRITE_HEADER: begin
                if (req_q && ram_write_grant) begin
                    addr_d  = addr_q + 16'd1;
                    wdata_d = data_q[0];
                    byte_d  = '0;
                    state_d = S_WRITE_DATA;
                end
            end
            S_WRITE_DATA: begin
                if (req_q && ram_write_grant) begin
                    addr_d = addr_q + 16'd1;
                    if (byte_q == 3'd7) begin
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = last_q ? S_IDLE : S_FILL;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        wdata_d = data_q[byte_q + 3'd1];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state lives here; reset abandons any block and drops the request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            for (int i = 0; i < 16; i++) buf_q[i] <= '0;
            for (int i = 0; i < 8; i++) data_q[i] <= '0;
            idx_q    <= '0;
            range_q  <= '0;
            filter_q <= '0;
            last_q   <= 1'b0;
            loop_q   <= 1'b0;
            byte_q   <= '0;
            req_q    <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            buf_q    <= buf_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            range_q  <= range_d;
            filter_q <= filter_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
            byte_q   <= byte_d;
            req_q    <= req_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
        end
    end

    assign sample_ready      = (state_q == S_FILL);
    assign ram_address       = addr_q;
    assign ram_write_data    = wdata_q;
    assign ram_write_request = req_q;
    assign busy              = (state_q != S_IDLE);
    assign block_done        = done_q;
    assign state             = state_q;

endmodule

// File: tb/tb_dsp_brr_encoder.sv
module tb_dsp_brr_encoder;

    localparam int MAX_RANGE = 12;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_address = '0;
    logic [1:0]  filter_select = '0;
    logic        last_block = 1'b0;
    logic        loop_flag = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] ram_address;
    logic [7:0]  ram_write_data;
    logic        ram_write_request;
    logic        ram_write_grant = 1'b0;
    logic        busy;
    logic        block_done;
    logic [2:0]  state;

    always #5 clock = ~clock;

    dsp_brr_encoder #(.MAX_RANGE(MAX_RANGE)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
        .filter_select(filter_select), .last_block(last_block), .loop_flag(loop_flag),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_write_request(ram_write_request), .ram_write_grant(ram_write_grant),
        .busy(busy), .block_done(block_done), .state(state)
    );

    typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;

    wr_t         wr_q[$];
    int          rd_ptr = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          grant_mode = 0;
    logic        manual_grant = 1'b0;
    int          m_s1 = 0;
    int          m_s2 = 0;
    logic [15:0] m_addr = '0;
    int          dec_q[$];

    // RAM side: choose the grant each cycle and log every accepted write.
    initial begin : ram_monitor
        forever begin
            @(negedge clock);
            case (grant_mode)
                0:       ram_write_grant = 1'b1;
                1:       ram_write_grant = 1'($urandom_range(0, 1));
                default: ram_write_grant = manual_grant;
            endcase
            #1;
            if (ram_write_request && ram_write_grant)
                wr_q.push_back({ram_address, ram_write_data});
            if (block_done)
                done_cnt++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decoder arithmetic: '/' on int truncates toward zero.
    function automatic int predict(input int f, input int a, input int b);
        case (f)
            1:       return a * 15 / 16;
            2:       return a * 61 / 32 + b * (-15) / 16;
            3:       return a * 115 / 64 + b * (-13) / 16;
            default: return 0;
        endcase
    endfunction

    function automatic int wrap16(input int x);
        int y;
        y = x & 32'hFFFF;
        if (y >= 32768) y = y - 65536;
        return y;
    endfunction

    function automatic int rand_sample();
        logic signed [15:0] t;
        t = 16'($urandom_range(0, 65535));
        t = t >>> $urandom_range(0, 15);
        return int'(t);
    endfunction

    // Reference encoder: whole-block range search, then closed-loop quantisation.
    task automatic model_block(input int smp[16], input int f, input bit last, input bit lp,
                               output logic [7:0] eb[9], output logic [15:0] ea[9]);
        int rng, ri, p1, p2, resid, p, n, dec, nib;
        logic [7:0] d[8];
        rng = 0;
        for (int i = 0; i < 16; i++) begin
            p1 = (i >= 1) ? smp[i-1] : m_s1;
            p2 = (i >= 2) ? smp[i-2] : ((i == 1) ? m_s1 : m_s2);
            resid = smp[i] - predict(f, p1, p2);
            ri = MAX_RANGE;
            for (int r = MAX_RANGE; r >= 0; r--)
                if ((resid >>> r) >= -8 && (resid >>> r) <= 7) ri = r;
            if (ri > rng) rng = ri;
        end
        for (int i = 0; i < 16; i++) begin
            p = predict(f, m_s1, m_s2);
            n = (smp[i] - p) >>> rng;
            if (n > 7) n = 7;
            if (n < -8) n = -8;
            dec = wrap16(n * (1 << rng) + p);
            m_s2 = m_s1;
            m_s1 = dec;
            dec_q.push_back(dec);
            nib = n & 15;
            if (i % 2 == 0) d[i/2][7:4] = nib[3:0];
            else            d[i/2][3:0] = nib[3:0];
        end
        eb[0] = {rng[3:0], f[1:0], lp, last};
        for (int k = 0; k < 8; k++) eb[k+1] = d[k];
        for (int k = 0; k < 9; k++) begin
            ea[k] = m_addr;
            m_addr = m_addr + 16'd1;
        end
    endtask

    task automatic do_start(input logic [15:0] a);
        start_address = a;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        m_s1 = 0;
        m_s2 = 0;
        m_addr = a;
    endtask

    task automatic send_samples(input int smp[16], input int f, input bit last, input bit lp,
                                output bit ok);
        int n;
        ok = 1'b1;
        filter_select = 2'(f);
        last_block = last;
        loop_flag = lp;
        for (int i = 0; i < 16; i++) begin
            sample_in = 16'(smp[i]);
            sample_valid = 1'b1;
            n = 0;
            while (sample_ready !== 1'b1 && n < 200) begin
                @(negedge clock);
                n++;
            end
            if (n >= 200) ok = 1'b0;
            @(negedge clock);
            sample_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end
    endtask

    task automatic run_block(input int smp[16], input int f, input bit last, input bit lp,
                             output bit ok);
        int base, n;
        bit ok1;
        base = done_cnt;
        send_samples(smp, f, last, lp, ok1);
        n = 0;
        while (done_cnt == base && n < 500) begin
            @(negedge clock);
            #2;
            n++;
        end
        ok = ok1 && (done_cnt != base);
    endtask

    task automatic take_bytes(output logic [7:0] ab[9], output logic [15:0] aa[9]);
        for (int k = 0; k < 9; k++) begin
            if (rd_ptr < wr_q.size()) begin
                aa[k] = wr_q[rd_ptr].addr;
                ab[k] = wr_q[rd_ptr].data;
                rd_ptr++;
            end else begin
                aa[k] = 'x;
                ab[k] = 'x;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if (ram_write_request !== 1'b0 || block_done !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pulses: got req=%b done=%b expected 0/0", ram_write_request, block_done);
        end
        checks++;
        if (ram_address !== 16'h0 || ram_write_data !== 8'h0) begin
            errors++; $display("[TB] FAIL reset_port: got %h/%h expected 0000/00", ram_address, ram_write_data);
        end
        checks++;
        if (busy !== 1'b0 || sample_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got busy=%b ready=%b expected 0/0", busy, sample_ready);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_zero_block();
        int smp[16];
        logic [7:0] eb[9], ab[9];
        logic [15:0] ea[9], aa[9];
        bit ok;
        int base;
        grant_mode = 0;
        for (int i = 0; i < 16; i++) smp[i] = 0;
        do_start(16'h1000);
        model_block(smp, 0, 1'b1, 1'b0, eb, ea);
        base = done_cnt;
        run_block(smp, 0, 1'b1, 1'b0, ok);
        repeat (4) @(negedge clock);
        take_bytes(ab, aa);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL zero_timeout: got no block_done expected one"); end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (aa[k] !== ea[k] || ab[k] !== eb[k]) begin
                errors++; $display("[TB] FAIL zero_byte%0d: got %h@%h expected %h@%h", k, ab[k], aa[k], eb[k], ea[k]);
            end
        end
        checks++;
        if (ab[0] !== 8'h01 || aa[0] !== 16'h1000) begin
            errors++; $display("[TB] FAIL zero_header: got %h@%h expected 01@1000", ab[0], aa[0]);
        end
        checks++;
        if (done_cnt - base !== 1 || state !== 3'd0 || rd_ptr !== wr_q.size()) begin
            errors++; $display("[TB] FAIL zero_end: got done=%0d state=%0d extra=%0d expected 1/0/0",
                               done_cnt - base, state, wr_q.size() - rd_ptr);
        end
    endtask

    // Three blocks streamed back to back: constant 7s, alternating, extremes.
    task automatic test_back_to_back();
        int smp[16];
        logic [7:0] eb[9], ab[9];
        logic [15:0] ea[9], aa[9];
        logic [7:0] want_hdr, want_data;
        bit ok, last;
        grant_mode = 0;
        do_start(16'h1000);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) begin
                case (b)
                    0:       smp[i] = 7;
                    1:       smp[i] = (i % 2 == 0) ? 256 : -256;
                    default: smp[i] = (i % 2 == 0) ? 32767 : -32768;
                endcase
            end
            last = (b == 2);
            want_hdr  = (b == 0) ? 8'h00 : (b == 1) ? 8'h60 : 8'hC1;
            want_data = (b == 0) ? 8'h77 : (b == 1) ? 8'h4C : 8'h78;
            model_block(smp, 0, last, 1'b0, eb, ea);
            run_block(smp, 0, last, 1'b0, ok);
            take_bytes(ab, aa);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL stream%0d_timeout: got no block_done expected one", b); end
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (aa[k] !== ea[k] || ab[k] !== eb[k]) begin
                    errors++; $display("[TB] FAIL stream%0d_byte%0d: got %h@%h expected %h@%h", b, k, ab[k], aa[k], eb[k], ea[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (ab[k] !== want_data) begin
                        errors++; $display("[TB] FAIL stream%0d_const%0d: got %h expected %h", b, k, ab[k], want_data);
                    end
                end
            end
            checks++;
            if (ab[0] !== want_hdr) begin
                errors++; $display("[TB] FAIL stream%0d_header: got %h expected %h", b, ab[0], want_hdr);
            end
            if (b == 0) begin
                checks++;
                if (state !== 3'd1 || ram_address !== 16'h1009) begin
                    errors++; $display("[TB] FAIL stream0_resume: got state=%0d addr=%h expected 1/1009", state, ram_address);
                end
            end
        end
        checks++;
        if (state !== 3'd0) begin errors++; $display("[TB] FAIL stream_idle: got %0d expected 0", state); end
    endtask

    task automatic test_grant_stall();
        int smp[16];
        logic [7:0] eb[9], ab[9];
        logic [15:0] ea[9], aa[9];
        bit ok;
        int n, f;
        grant_mode = 0;
        f = $urandom_range(0, 3);
        for (int i = 0; i < 16; i++) smp[i] = rand_sample();
        do_start(16'h2000);
        model_block(smp, f, 1'b1, 1'b0, eb, ea);
        fork
            run_block(smp, f, 1'b1, 1'b0, ok);
            begin
                n = 0;
                while (!(ram_write_request === 1'b1 && ram_address === 16'h2003) && n < 300) begin
                    @(negedge clock);
                    #2;
                    n++;
                end
                manual_grant = 1'b0;
                grant_mode = 2;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clock);
                    #2;
                    checks++;
                    if (ram_write_request !== 1'b1 || ram_address !== 16'h2004 || ram_write_data !== eb[4]) begin
                        errors++; $display("[TB] FAIL stall_hold%0d: got req=%b %h@%h expected 1 %h@2004",
                                           c, ram_write_request, ram_write_data, ram_address, eb[4]);
                    end
                end
                grant_mode = 0;
            end
        join
        take_bytes(ab, aa);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL stall_timeout: got no block_done expected one"); end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (aa[k] !== ea[k] || ab[k] !== eb[k]) begin
                errors++; $display("[TB] FAIL stall_byte%0d: got %h@%h expected %h@%h", k, ab[k], aa[k], eb[k], ea[k]);
            end
        end
        checks++;
        if (rd_ptr !== wr_q.size()) begin
            errors++; $display("[TB] FAIL stall_extra: got %0d extra writes expected 0", wr_q.size() - rd_ptr);
        end
    endtask

    // Random filters and amplitudes, random grants, address wrap at 0xFFFF.
    task automatic test_random_blocks();
        int smp[16];
        logic [7:0] eb[9], ab[9];
        logic [15:0] ea[9], aa[9];
        bit ok, last;
        int f;
        grant_mode = 1;
        do_start(16'hFFFC);
        for (int b = 0; b < 4; b++) begin
            f = $urandom_range(0, 3);
            last = (b == 3);
            for (int i = 0; i < 16; i++) smp[i] = rand_sample();
            model_block(smp, f, last, b[0], eb, ea);
            run_block(smp, f, last, b[0], ok);
            take_bytes(ab, aa);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL rand%0d_timeout: got no block_done expected one", b); end
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (aa[k] !== ea[k] || ab[k] !== eb[k]) begin
                    errors++; $display("[TB] FAIL rand%0d_byte%0d: got %h@%h expected %h@%h", b, k, ab[k], aa[k], eb[k], ea[k]);
                end
            end
        end
        checks++;
        if (state !== 3'd0) begin errors++; $display("[TB] FAIL rand_idle: got %0d expected 0", state); end
    endtask

    // Encode a ramp with filter 1, then play the written bytes back through a decoder model.
    task automatic test_f1_ramp();
        int smp[16];
        logic [7:0] eb[9], ab[9], ram[27];
        logic [15:0] ea[9], aa[9];
        logic [7:0] hdr, by;
        bit ok, last;
        int s1, s2, s, n, rng, filt, nib;
        grant_mode = 1;
        dec_q.delete();
        do_start(16'h3000);
        for (int i = 0; i < 16; i++) smp[i] = i * 64;
        for (int b = 0; b < 3; b++) begin
            last = (b == 2);
            model_block(smp, 1, last, 1'b0, eb, ea);
            run_block(smp, 1, last, 1'b0, ok);
            take_bytes(ab, aa);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL ramp%0d_timeout: got no block_done expected one", b); end
            for (int k = 0; k < 9; k++) begin
                ram[b*9 + k] = ab[k];
                checks++;
                if (aa[k] !== ea[k] || ab[k] !== eb[k]) begin
                    errors++; $display("[TB] FAIL ramp%0d_byte%0d: got %h@%h expected %h@%h", b, k, ab[k], aa[k], eb[k], ea[k]);
                end
            end
        end
        s1 = 0;
        s2 = 0;
        for (int b = 0; b < 3; b++) begin
            hdr = ram[b*9];
            rng = int'(hdr[7:4]);
            filt = int'(hdr[3:2]);
            for (int i = 0; i < 16; i++) begin
                by = ram[b*9 + 1 + i/2];
                nib = (i % 2 == 0) ? int'(by[7:4]) : int'(by[3:0]);
                n = (nib >= 8) ? nib - 16 : nib;
                s = wrap16(n * (1 << rng) + predict(filt, s1, s2));
                s2 = s1;
                s1 = s;
                checks++;
                if (s !== dec_q[b*16 + i]) begin
                    errors++; $display("[TB] FAIL ramp_decode%0d: got %0d expected %0d", b*16 + i, s, dec_q[b*16 + i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int smp[16];
        bit ok;
        int n, base;
        manual_grant = 1'b0;
        grant_mode = 2;
        for (int i = 0; i < 16; i++) smp[i] = rand_sample();
        do_start(16'h4000);
        send_samples(smp, 2, 1'b1, 1'b0, ok);
        n = 0;
        while (state !== 3'd4 && n < 100) begin
            @(negedge clock);
            #2;
            n++;
        end
        manual_grant = 1'b1;
        repeat (2) begin @(negedge clock); #2; end
        manual_grant = 1'b0;
        @(negedge clock);
        #2;
        checks++;
        if (!ok || state !== 3'd5 || ram_address !== 16'h4002) begin
            errors++; $display("[TB] FAIL midreset_setup: got ok=%b state=%0d addr=%h expected 1/5/4002", ok, state, ram_address);
        end
        base = wr_q.size();
        reset_n = 1'b0;
        #1;
        checks++;
        if (ram_write_request !== 1'b0 || state !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_abort: got req=%b state=%0d busy=%b expected 0/0/0", ram_write_request, state, busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        grant_mode = 0;
        repeat (40) @(negedge clock);
        #2;
        checks++;
        if (wr_q.size() !== base || state !== 3'd0) begin
            errors++; $display("[TB] FAIL midreset_quiet: got %0d writes state=%0d expected 0/0", wr_q.size() - base, state);
        end
        rd_ptr = wr_q.size();
    endtask

    initial begin : main
        test_reset();
        test_zero_block();
        test_back_to_back();
        test_grant_stall();
        test_random_blocks();
        test_f1_ramp();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
